// File: rtl/usb_pll_ctrl.sv
// USB PLL power-up sequencer: reset hold, charge-pump/loop-filter setup, lock qualification and retry.
// Optional build macro PLL_RETRY_CAL_EN steps ICP/LPF codes on each failed attempt.
module usb_pll_ctrl #(
    parameter int unsigned RST_HOLD_CYC     = 64,
    parameter int unsigned LOCK_TIMEOUT_CYC = 24000,
    parameter int unsigned LOCK_STABLE_CYC  = 256,
    parameter int unsigned MAX_RETRY        = 3,
    parameter logic [5:0]  ICP_DEFAULT      = 6'd16,
    parameter logic [2:0]  LPF_RES_DEFAULT  = 3'd2,
    parameter logic [1:0]  LPF_CAP_DEFAULT  = 2'd0
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] icpsel,
    output logic [2:0] lpfres,
    output logic [1:0] lpfcap,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic       lock_lost,
    output logic [1:0] retry_cnt
);

    localparam int unsigned CNT_W   = 15;
    localparam int unsigned RETRY_W = 2;

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RST_HOLD  = 3'd1;
    localparam logic [2:0] WAIT_LOCK = 3'd2;
    localparam logic [2:0] STABLE    = 3'd3;
    localparam logic [2:0] READY     = 3'd4;
    localparam logic [2:0] FAIL      = 3'd5;

    logic [2:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   tmo_cnt, tmo_nxt;
    logic [RETRY_W-1:0] retry_nxt, retry_inc;
    logic [5:0]         icp_nxt;
    logic [2:0]         lpfres_nxt;
    logic [1:0]         lpfcap_nxt;
    logic               pll_reset_nxt, ready_nxt, fail_nxt, lost_nxt;
    logic               attempt_fail;
    logic               lock_meta, lock_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchroniser for the PLL lock, which is asynchronous to clkin.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            icpsel    <= ICP_DEFAULT;
            lpfres    <= LPF_RES_DEFAULT;
            lpfcap    <= LPF_CAP_DEFAULT;
            pll_ready <= 1'b0;
            pll_fail  <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tmo_cnt   <= tmo_nxt;
            retry_cnt <= retry_nxt;
            pll_reset <= pll_reset_nxt;
            icpsel    <= icp_nxt;
            lpfres    <= lpfres_nxt;
            lpfcap    <= lpfcap_nxt;
            pll_ready <= ready_nxt;
            pll_fail  <= fail_nxt;
            lock_lost <= lost_nxt;
        end
    end

    assign retry_inc = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + RETRY_W'(1);

`ifdef PLL_RETRY_CAL_EN
    logic [6:0] icp_sum;
    logic [3:0] lpf_sum;
    assign icp_sum = {1'b0, ICP_DEFAULT} + 7'({retry_inc, 3'b000});
    assign lpf_sum = {1'b0, LPF_RES_DEFAULT} + 4'(retry_inc);
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        tmo_nxt      = tmo_cnt;
        retry_nxt    = retry_cnt;
        icp_nxt      = icpsel;
        lpfres_nxt   = lpfres;
        lpfcap_nxt   = lpfcap;
        ready_nxt    = 1'b0;
        fail_nxt     = 1'b0;
        lost_nxt     = 1'b0;
        attempt_fail = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            tmo_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = RST_HOLD;
                    cnt_nxt    = '0;
                    retry_nxt  = '0;
                    icp_nxt    = ICP_DEFAULT;
                    lpfres_nxt = LPF_RES_DEFAULT;
                    lpfcap_nxt = LPF_CAP_DEFAULT;
                end
                RST_HOLD: begin
                    if (cnt >= RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                        tmo_nxt   = '0;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
                WAIT_LOCK: begin
                    tmo_nxt = sat_inc(tmo_cnt);
                    if (lock_s) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        attempt_fail = 1'b1;
                    end
                end
                // Timeout keeps running here so glitchy lock cannot extend an attempt indefinitely.
                STABLE: begin
                    tmo_nxt = sat_inc(tmo_cnt);
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt >= STB_LAST) begin
                        state_nxt = READY;
                        ready_nxt = 1'b1;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
                READY: begin
                    if (!lock_s) begin
                        state_nxt = RST_HOLD;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                        lost_nxt  = 1'b1;
                    end else begin
                        ready_nxt = 1'b1;
                    end
                end
                FAIL: begin
                    fail_nxt = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (attempt_fail) begin
                retry_nxt = retry_inc;
                cnt_nxt   = '0;
                if (retry_inc == RETRY_MAX) begin
                    state_nxt = FAIL;
                    fail_nxt  = 1'b1;
                end else begin
                    state_nxt = RST_HOLD;
`ifdef PLL_RETRY_CAL_EN
                    icp_nxt    = (icp_sum > 7'd63) ? 6'd63 : icp_sum[5:0];
                    lpfres_nxt = (lpf_sum > 4'd7) ? 3'd7 : lpf_sum[2:0];
`endif
                end
            end
        end

        pll_reset_nxt = !((state_nxt == WAIT_LOCK) || (state_nxt == STABLE) || (state_nxt == READY));
    end

endmodule
